// File: rtl/gpio_register_pkg.sv
// rtl/gpio_register_pkg.sv - GPIO register file constants and byte-merge helper
package gpio_register_pkg;

    localparam int          GPIO_W_DEFAULT  = 16;
    localparam logic [15:0] TRI_RST_DEFAULT = 16'hFFFF;

    localparam logic [2:0] ADDR_TRISTATE   = 3'd0;
    localparam logic [2:0] ADDR_DATAREG    = 3'd1;
    localparam logic [2:0] ADDR_INT_MASK   = 3'd2;
    localparam logic [2:0] ADDR_PINSTATE   = 3'd3;
    localparam logic [2:0] ADDR_INT_STATUS = 3'd4;

    // Replace the bytes of cur selected by be with the matching bytes of wd.
    function automatic logic [15:0] byte_merge(input logic [15:0] cur,
                                               input logic [15:0] wd,
                                               input logic [1:0]  be);
        logic [15:0] merged;
        merged = cur;
        if (be[0]) merged[7:0]  = wd[7:0];
        if (be[1]) merged[15:8] = wd[15:8];
        return merged;
    endfunction

endpackage

// File: rtl/gpio_pin_sampler.sv
// rtl/gpio_pin_sampler.sv - pin sampling and change detect; GPIO_REGISTER_SYNC_EN adds a 2-flop synchronizer
module gpio_pin_sampler #(
    parameter int GPIO_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [GPIO_W-1:0] pins,
    output logic [GPIO_W-1:0] pin_q,
    output logic [GPIO_W-1:0] change
);

    logic [GPIO_W-1:0] pin_prev;
    logic [GPIO_W-1:0] pin_src;

`ifdef GPIO_REGISTER_SYNC_EN
    logic [GPIO_W-1:0] sync1;
    logic [GPIO_W-1:0] sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    assign pin_src = sync2;
`else
    assign pin_src = pins;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pin_q    <= '0;
            pin_prev <= '0;
        end else begin
            pin_q    <= pin_src;
            pin_prev <= pin_q;
        end
    end

    assign change = pin_q ^ pin_prev;

endmodule

// File: rtl/gpio_register.sv
// rtl/gpio_register.sv - GPIO control/status register file (optional GPIO_REGISTER_SYNC_EN pin synchronizer)
module gpio_register
    import gpio_register_pkg::*;
#(
    parameter int          GPIO_W  = GPIO_W_DEFAULT,
    parameter logic [15:0] TRI_RST = TRI_RST_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        addr,
    input  logic [3:0]        wben,
    input  logic              r_wn,
    input  logic [31:0]       wdata,
    input  logic [GPIO_W-1:0] ro_gpio_pinstate,
    output logic [31:0]       rdata,
    output logic [GPIO_W-1:0] rf_gpio_tristate,
    output logic [GPIO_W-1:0] rf_gpio_datareg,
    output logic [GPIO_W-1:0] rf_gpio_interrupt_mask,
    output logic              irq
);

    logic [GPIO_W-1:0] int_status;
    logic [GPIO_W-1:0] pin_q;
    logic [GPIO_W-1:0] change;
    logic [GPIO_W-1:0] w1c_clr;
    logic [GPIO_W-1:0] rd_sel;
    logic              wr_en;
    logic              unused_bits;

    assign unused_bits = ^{wdata[31:16], wben[3:2]};

    gpio_pin_sampler #(.GPIO_W(GPIO_W)) u_sampler (
        .clock  (clock),
        .reset  (reset),
        .pins   (ro_gpio_pinstate),
        .pin_q  (pin_q),
        .change (change)
    );

    assign wr_en = !r_wn;

    // Only enabled bytes of wdata can clear status bits.
    assign w1c_clr = (wr_en && addr == ADDR_INT_STATUS)
                   ? byte_merge(16'h0000, wdata[15:0], wben[1:0]) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_gpio_tristate       <= TRI_RST;
            rf_gpio_datareg        <= '0;
            rf_gpio_interrupt_mask <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_TRISTATE: rf_gpio_tristate <=
                    byte_merge(rf_gpio_tristate, wdata[15:0], wben[1:0]);
                ADDR_DATAREG: rf_gpio_datareg <=
                    byte_merge(rf_gpio_datareg, wdata[15:0], wben[1:0]);
                ADDR_INT_MASK: rf_gpio_interrupt_mask <=
                    byte_merge(rf_gpio_interrupt_mask, wdata[15:0], wben[1:0]);
                default: ;
            endcase
        end
    end

    // OR-ing the new events after the clear makes a same-edge set win.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            int_status <= '0;
        end else begin
            int_status <= (int_status & ~w1c_clr) | (change & rf_gpio_interrupt_mask);
        end
    end

    always_comb begin
        rd_sel = '0;
        case (addr)
            ADDR_TRISTATE:   rd_sel = rf_gpio_tristate;
            ADDR_DATAREG:    rd_sel = rf_gpio_datareg;
            ADDR_INT_MASK:   rd_sel = rf_gpio_interrupt_mask;
            ADDR_PINSTATE:   rd_sel = pin_q;
            ADDR_INT_STATUS: rd_sel = int_status;
            default:         rd_sel = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (r_wn) begin
            rdata <= {{(32-GPIO_W){1'b0}}, rd_sel};
        end
    end

    assign irq = |int_status;

endmodule

// File: tb/tb_gpio_register.sv
// tb/tb_gpio_register.sv - directed self-checking bench for gpio_register
module tb_gpio_register;

`ifdef GPIO_REGISTER_SYNC_EN
    localparam int LAG = 3;
`else
    localparam int LAG = 1;
`endif

    logic        clock;
    logic        reset;
    logic [2:0]  addr;
    logic [3:0]  wben;
    logic        r_wn;
    logic [31:0] wdata;
    logic [15:0] ro_gpio_pinstate;
    logic [31:0] rdata;
    logic [15:0] rf_gpio_tristate;
    logic [15:0] rf_gpio_datareg;
    logic [15:0] rf_gpio_interrupt_mask;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] rv;

    gpio_register dut (
        .clock                  (clock),
        .reset                  (reset),
        .addr                   (addr),
        .wben                   (wben),
        .r_wn                   (r_wn),
        .wdata                  (wdata),
        .ro_gpio_pinstate       (ro_gpio_pinstate),
        .rdata                  (rdata),
        .rf_gpio_tristate       (rf_gpio_tristate),
        .rf_gpio_datareg        (rf_gpio_datareg),
        .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask),
        .irq                    (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        r_wn  = 1'b0;
        wben  = 4'b0000;
        addr  = 3'd7;
        wdata = 32'h0;
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; wben = be; r_wn = 1'b0;
        @(negedge clock);
        idle();
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr = a; r_wn = 1'b1; wben = 4'b0000;
        @(negedge clock);
        idle();
        d = rdata;
    endtask

    initial begin
        idle();
        ro_gpio_pinstate = 16'h0000;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_tristate", {16'h0, rf_gpio_tristate}, 32'h0000FFFF);
        chk("rst_datareg",  {16'h0, rf_gpio_datareg},  32'h0);
        chk("rst_mask",     {16'h0, rf_gpio_interrupt_mask}, 32'h0);
        chk("rst_rdata",    rdata, 32'h0);
        chk("rst_irq",      {31'h0, irq}, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        rd(3'd0, rv); chk("rd_tristate", rv, 32'h0000FFFF);
        rd(3'd1, rv); chk("rd_datareg",  rv, 32'h0);
        rd(3'd2, rv); chk("rd_mask",     rv, 32'h0);
        rd(3'd4, rv); chk("rd_status",   rv, 32'h0);
        chk("irq_idle", {31'h0, irq}, 32'h0);

        wr(3'd1, 32'hDEADA5C3, 4'b1111);
        chk("datareg_full", {16'h0, rf_gpio_datareg}, 32'h0000A5C3);
        rd(3'd1, rv); chk("rd_datareg_full", rv, 32'h0000A5C3);

        wr(3'd0, 32'h00001234, 4'b0001);
        chk("tri_byte0", {16'h0, rf_gpio_tristate}, 32'h0000FF34);
        wr(3'd0, 32'h00005600, 4'b0010);
        chk("tri_byte1", {16'h0, rf_gpio_tristate}, 32'h00005634);
        wr(3'd1, 32'hFFFFFFFF, 4'b0000);
        chk("wben_zero", {16'h0, rf_gpio_datareg}, 32'h0000A5C3);
        wr(3'd1, 32'hFFFFFFFF, 4'b1100);
        chk("wben_upper", {16'h0, rf_gpio_datareg}, 32'h0000A5C3);
        chk("rdata_hold", rdata, 32'h0000A5C3);

        ro_gpio_pinstate = 16'h00F0;
        rd(3'd3, rv); chk("pin_before_lag", rv, 32'h0);
        repeat (LAG - 1) @(negedge clock);
        rd(3'd3, rv); chk("pin_after_lag", rv, 32'h000000F0);
        repeat (2) @(negedge clock);
        rd(3'd4, rv); chk("masked_change", rv, 32'h0);

        wr(3'd2, 32'h00000001, 4'b0011);
        chk("mask_set", {16'h0, rf_gpio_interrupt_mask}, 32'h00000001);
        ro_gpio_pinstate = 16'h00F1;
        repeat (LAG + 1) @(negedge clock);
        chk("irq_pin0", {31'h0, irq}, 32'h1);
        rd(3'd4, rv); chk("status_pin0", rv, 32'h00000001);
        ro_gpio_pinstate = 16'h00F3;
        repeat (LAG + 2) @(negedge clock);
        rd(3'd4, rv); chk("status_pin1_masked", rv, 32'h00000001);
        wr(3'd4, 32'h00000001, 4'b0001);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        rd(3'd4, rv); chk("status_cleared", rv, 32'h0);

        ro_gpio_pinstate = 16'h00F2;
        repeat (LAG + 1) @(negedge clock);
        chk("status_pre_race", {31'h0, irq}, 32'h1);
        ro_gpio_pinstate = 16'h00F3;
        repeat (LAG) @(negedge clock);
        wr(3'd4, 32'h00000001, 4'b0001);
        rd(3'd4, rv); chk("set_wins_w1c", rv, 32'h00000001);
        wr(3'd4, 32'h00000001, 4'b0001);
        rd(3'd4, rv); chk("status_clear2", rv, 32'h0);

        ro_gpio_pinstate = 16'h00F2;
        repeat (LAG + 1) @(negedge clock);
        wr(3'd2, 32'h00000000, 4'b0011);
        rd(3'd4, rv); chk("mask_clr_keeps", rv, 32'h00000001);
        wr(3'd4, 32'h0000FFFF, 4'b0011);
        chk("irq_final", {31'h0, irq}, 32'h0);

        wr(3'd6, 32'hFFFFFFFF, 4'b1111);
        rd(3'd6, rv); chk("rd_reserved6", rv, 32'h0);
        rd(3'd5, rv); chk("rd_reserved5", rv, 32'h0);
        chk("res_tristate", {16'h0, rf_gpio_tristate}, 32'h00005634);
        chk("res_datareg",  {16'h0, rf_gpio_datareg},  32'h0000A5C3);
        chk("res_mask",     {16'h0, rf_gpio_interrupt_mask}, 32'h0);
        rd(3'd4, rv); chk("res_status", rv, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
